// File: rtl/predictor_func_pkg.sv
// Shared definitions for the predictor loop-body pipeline controller:
// FSM encoding, handshake bit levels and a width helper.
package predictor_func_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  localparam logic HS_ASSERT   = 1'b1;
  localparam logic HS_DEASSERT = 1'b0;

  // Minimum bits needed to index 0..value-1 (0 for value<=1).
  function automatic int clog2(input int value);
    int result;
    int rem;
    result = 0;
    rem    = value - 1;
    while (rem > 0) begin
      result = result + 1;
      rem    = rem >> 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/predictor_func_valid_shreg.sv
// Parallel-out shift register carrying one flag per pipeline stage;
// bit 0 captures din, bit k takes bit k-1 every cycle.
module predictor_func_valid_shreg
  import predictor_func_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             din,
  output logic [DEPTH-1:0] q
);

  logic [DEPTH-1:0] q_d;
  logic [DEPTH-1:0] q_q;

  always_comb begin
    q_d    = q_q;
    q_d[0] = din;
    for (int k = 1; k < DEPTH; k++) begin
      q_d[k] = q_q[k-1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_q <= {DEPTH{HS_DEASSERT}};
    end else begin
      q_q <= q_d;
    end
  end

  assign q = q_q;

endmodule

// File: rtl/predictor_func_loop_body_pipe_ctrl.sv
// Loop-body flow control: issues TRIP_COUNT iterations at II=1 into a
// DEPTH-stage datapath and reports ready/done back to the loop wrapper.
module predictor_func_loop_body_pipe_ctrl
  import predictor_func_pkg::*;
#(
  parameter int TRIP_COUNT = 16,
  parameter int DEPTH      = 4,
  parameter int CNT_W      = 5
) (
  input  logic             ap_clk,
  input  logic             ap_rst_n,
  input  logic             ap_start_int,
  input  logic             ap_continue_int,
  input  logic             ap_loop_init,
  output logic             ap_ready_int,
  output logic             ap_done_int,
  output logic             ap_loop_exit_ready,
  output logic             ap_loop_exit_done,
  output logic [CNT_W-1:0] iter_idx,
  output logic [DEPTH-1:0] stage_valid
);

  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(TRIP_COUNT - 1);

  if (clog2(TRIP_COUNT) > CNT_W) begin : g_cnt_w_check
    $error("CNT_W too narrow for TRIP_COUNT");
  end

  state_e           state_q, state_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [CNT_W-1:0] idx;
  logic             issue;
  logic             exit_ready;
  logic             drain_hit;

  // Issue is gated by reset so every output reads 0 while ap_rst_n is low.
  always_comb begin
    issue      = ap_rst_n & ap_start_int & (state_q != ST_DRAIN) & (state_q != ST_DONE);
    idx        = ap_loop_init ? '0 : count_q;
    exit_ready = issue & (idx == LAST_IDX);
    count_d    = count_q;
    if (issue) begin
      count_d = exit_ready ? '0 : idx + 1'b1;
    end
  end

  predictor_func_valid_shreg #(.DEPTH(DEPTH)) u_stage_valid (
    .clk   (ap_clk),
    .rst_n (ap_rst_n),
    .din   (issue),
    .q     (stage_valid)
  );

  // Done is registered, so the FSM must move when the last token is about to
  // enter the final stage; the last-token tracker stops one stage short.
  if (DEPTH > 1) begin : g_last_sr
    logic [DEPTH-2:0] last_sr;

    predictor_func_valid_shreg #(.DEPTH(DEPTH-1)) u_last_sr (
      .clk   (ap_clk),
      .rst_n (ap_rst_n),
      .din   (exit_ready),
      .q     (last_sr)
    );

    assign drain_hit = last_sr[DEPTH-2];
  end else begin : g_no_last_sr
    assign drain_hit = HS_DEASSERT;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE, ST_RUN: begin
        if (exit_ready) begin
          state_d = (DEPTH == 1) ? ST_DONE : ST_DRAIN;
        end else if (issue) begin
          state_d = ST_RUN;
        end
      end
      ST_DRAIN: begin
        if (drain_hit) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        if (ap_continue_int) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      state_q <= ST_IDLE;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
    end
  end

  assign ap_ready_int       = issue;
  assign ap_loop_exit_ready = exit_ready;
  assign iter_idx           = issue ? idx : '0;
  assign ap_done_int        = (state_q == ST_DONE) ? HS_ASSERT : HS_DEASSERT;
  assign ap_loop_exit_done  = (state_q == ST_DONE) & ap_continue_int;

endmodule

// File: tb/tb_predictor_func_loop_body_pipe_ctrl.sv
// Directed bench for the loop-body pipeline controller: a TRIP_COUNT=4/DEPTH=3
// instance and a TRIP_COUNT=1/DEPTH=1 instance checked against hand tables.
module tb_predictor_func_loop_body_pipe_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic       a_start, a_cont, a_init;
  logic       a_ready, a_done, a_exr, a_exd;
  logic [4:0] a_idx;
  logic [2:0] a_sv;
  logic       b_start, b_cont, b_init;
  logic       b_ready, b_done, b_exr, b_exd;
  logic [0:0] b_idx;
  logic [0:0] b_sv;

  int check_cnt = 0;
  int pass_cnt  = 0;

  predictor_func_loop_body_pipe_ctrl #(.TRIP_COUNT(4), .DEPTH(3), .CNT_W(5)) u_dut_a (
    .ap_clk             (clk),
    .ap_rst_n           (rst_n),
    .ap_start_int       (a_start),
    .ap_continue_int    (a_cont),
    .ap_loop_init       (a_init),
    .ap_ready_int       (a_ready),
    .ap_done_int        (a_done),
    .ap_loop_exit_ready (a_exr),
    .ap_loop_exit_done  (a_exd),
    .iter_idx           (a_idx),
    .stage_valid        (a_sv)
  );

  predictor_func_loop_body_pipe_ctrl #(.TRIP_COUNT(1), .DEPTH(1), .CNT_W(1)) u_dut_b (
    .ap_clk             (clk),
    .ap_rst_n           (rst_n),
    .ap_start_int       (b_start),
    .ap_continue_int    (b_cont),
    .ap_loop_init       (b_init),
    .ap_ready_int       (b_ready),
    .ap_done_int        (b_done),
    .ap_loop_exit_ready (b_exr),
    .ap_loop_exit_done  (b_exd),
    .iter_idx           (b_idx),
    .stage_valid        (b_sv)
  );

  // Stall-free run, TRIP_COUNT=4 DEPTH=3; bit c of each vector is cycle c.
  bit [7:0] t1_ready = 8'b0000_1111;
  bit [7:0] t1_exr   = 8'b0000_1000;
  bit [7:0] t1_done  = 8'b0100_0000;
  int       t1_idx[8] = '{0, 1, 2, 3, 0, 0, 0, 0};
  int       t1_sv[8]  = '{0, 1, 3, 7, 7, 6, 4, 0};

  // One bubble at cycle 1, continue held low on cycles 7-9.
  bit [11:0] t2_start = 12'b0000_0001_1101;
  bit [11:0] t2_cont  = 12'b1100_0111_1111;
  bit [11:0] t2_exr   = 12'b0000_0001_0000;
  bit [11:0] t2_done  = 12'b0111_1000_0000;
  bit [11:0] t2_exd   = 12'b0100_0000_0000;
  int        t2_idx[12] = '{0, 0, 1, 2, 3, 0, 0, 0, 0, 0, 0, 0};
  int        t2_sv[12]  = '{0, 1, 2, 5, 3, 7, 6, 4, 0, 0, 0, 0};

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    check_cnt++;
    if (obs === exp) begin
      pass_cnt++;
    end else begin
      $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic check_a(input string ph, input int c, input logic r, input int i,
                         input logic er, input logic d, input logic ed, input int sv);
    check_output($sformatf("%s c%0d ready", ph, c), 32'(a_ready), 32'(r));
    check_output($sformatf("%s c%0d idx", ph, c), 32'(a_idx), 32'(i));
    check_output($sformatf("%s c%0d exit_ready", ph, c), 32'(a_exr), 32'(er));
    check_output($sformatf("%s c%0d done", ph, c), 32'(a_done), 32'(d));
    check_output($sformatf("%s c%0d exit_done", ph, c), 32'(a_exd), 32'(ed));
    check_output($sformatf("%s c%0d stage_valid", ph, c), 32'(a_sv), 32'(sv));
  endtask

  // Stall-free run with continue high; start asserted on cycles set in start_pat.
  task automatic run_t1(input string ph, input bit [7:0] start_pat);
    for (int c = 0; c < 8; c++) begin
      a_start = start_pat[c];
      a_init  = (c == 0);
      a_cont  = 1'b1;
      @(negedge clk);
      check_a(ph, c, t1_ready[c], t1_idx[c], t1_exr[c], t1_done[c], t1_done[c], t1_sv[c]);
      next_cycle();
    end
    a_start = 1'b0;
    a_init  = 1'b0;
  endtask

  initial begin
    rst_n   = 1'b0;
    a_start = 1'b1;
    a_cont  = 1'b0;
    a_init  = 1'b0;
    b_start = 1'b0;
    b_cont  = 1'b0;
    b_init  = 1'b0;

    @(negedge clk);
    check_a("reset", 0, 1'b0, 0, 1'b0, 1'b0, 1'b0, 0);
    check_output("reset b done", 32'(b_done), 32'd0);
    a_start = 1'b0;
    next_cycle();
    rst_n = 1'b1;
    next_cycle();

    // Start also held through drain/done: must be ignored.
    run_t1("t1", 8'b0111_1111);

    // No loop_init: idx 0 proves the count stayed at 0 through drain.
    for (int c = 0; c < 12; c++) begin
      a_start = t2_start[c];
      a_init  = 1'b0;
      a_cont  = t2_cont[c];
      @(negedge clk);
      check_a("t2", c, t2_start[c], t2_idx[c], t2_exr[c], t2_done[c], t2_exd[c], t2_sv[c]);
      next_cycle();
    end
    a_start = 1'b0;
    a_cont  = 1'b1;

    for (int c = 0; c < 3; c++) begin
      b_start = (c == 0);
      b_init  = (c == 0);
      b_cont  = 1'b1;
      @(negedge clk);
      check_output($sformatf("b c%0d ready", c), 32'(b_ready), 32'(c == 0));
      check_output($sformatf("b c%0d exit_ready", c), 32'(b_exr), 32'(c == 0));
      check_output($sformatf("b c%0d idx", c), 32'(b_idx), 32'd0);
      check_output($sformatf("b c%0d done", c), 32'(b_done), 32'(c == 1));
      check_output($sformatf("b c%0d exit_done", c), 32'(b_exd), 32'(c == 1));
      check_output($sformatf("b c%0d stage_valid", c), 32'(b_sv), 32'(c == 1));
      next_cycle();
    end
    b_start = 1'b0;
    b_init  = 1'b0;

    // Abort a run with reset at cycle 2, then restart it.
    a_start = 1'b1;
    a_init  = 1'b1;
    @(negedge clk);
    check_a("abort", 0, 1'b1, 0, 1'b0, 1'b0, 1'b0, 0);
    next_cycle();
    a_init = 1'b0;
    @(negedge clk);
    check_a("abort", 1, 1'b1, 1, 1'b0, 1'b0, 1'b0, 1);
    next_cycle();
    rst_n = 1'b0;
    #1;
    check_a("abort", 2, 1'b0, 0, 1'b0, 1'b0, 1'b0, 0);
    next_cycle();
    rst_n   = 1'b1;
    a_start = 1'b0;
    for (int c = 3; c < 5; c++) begin
      @(negedge clk);
      check_a("abort", c, 1'b0, 0, 1'b0, 1'b0, 1'b0, 0);
      next_cycle();
    end
    run_t1("restart", 8'b0000_1111);

    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule
